exec_sequencer: RTL



---
 rtl/exec_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer: bus-master instruction sequencer.
// It fetches 32-bit instructions, reads operands from main or scratch memory,
// and pushes them into the matrix or integer ALU window. It then reads the
// result back and either writes it to a destination operand or uses it as a
// branch condition.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   nRead, nWrite   : active-low bus strobes (at most one low at a time)
//   address, wdata  : bus address / write data, held until ready is sampled
//   rdata, ready    : read data and access-complete handshake
//   pc              : current instruction index
//   halted, fault   : sticky stop flag; fault marks a bus-timeout halt
module exec_sequencer #(
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned PC_W         = 8,
    parameter logic [31:0] INSTR_BASE   = 32'h1000,
    parameter logic [31:0] MATRIX_BASE  = 32'h2000,
    parameter logic [31:0] INT_BASE     = 32'h3000,
    parameter logic [31:0] SCRATCH_BASE = 32'h4000,
    parameter int unsigned BUS_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              reset,
    output logic              nRead,
    output logic              nWrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_RD_A, S_RD_B, S_WR_A, S_WR_B, S_RD_RES, S_WB, S_HALT
    } state_t;

    state_t            st;
    logic [31:0]       ir;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [31:0]       wcnt;

    // Instruction fields
    logic [3:0] cls, op;
    logic [7:0] fd, fa, fb;
    assign cls = ir[31:28];
    assign op  = ir[27:24];
    assign fd  = ir[23:16];
    assign fa  = ir[15:8];
    assign fb  = ir[7:0];

    // Operand ref: low 7 bits are the offset, bit 7 selects scratch memory.
    function automatic logic [ADDR_W-1:0] oref(input logic [7:0] r);
        return ADDR_W'({25'd0, r[6:0]}) + (r[7] ? ADDR_W'(SCRATCH_BASE) : ADDR_W'(0));
    endfunction

    function automatic logic [ADDR_W-1:0] faddr(input logic [PC_W-1:0] p);
        return ADDR_W'(INSTR_BASE) + ADDR_W'(p);
    endfunction

    logic              is_imm;
    logic [ADDR_W-1:0] ubase;
    logic [31:0]       res_off;
    logic [ADDR_W-1:0] res_addr;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_br;
    logic [PC_W-1:0]   pc_cond;
    logic              bus_act;
    logic              timeout_hit;

    assign is_imm   = (op == 4'd7);
    assign ubase    = (cls == 4'd0) ? ADDR_W'(MATRIX_BASE) : ADDR_W'(INT_BASE);
    assign res_off  = (cls == 4'd2) ? ((32'(op) + 32'd10) << 8) : ((32'(op) + 32'd1) << 8);
    assign res_addr = ((cls == 4'd2) ? ADDR_W'(INT_BASE) : ubase) + ADDR_W'(res_off);
    assign pc_inc   = pc + PC_W'(1);
    // D is a signed offset; the sized cast sign-extends it to PC_W.
    assign pc_br    = pc + PC_W'($signed(fd));
    assign pc_cond  = (rdata == DATA_W'(1)) ? pc_br : pc_inc;
    assign bus_act  = !nRead || !nWrite;
    // The counter holds the number of wait cycles already seen; the edge that
    // would make it reach BUS_TIMEOUT abandons the access instead.
    assign timeout_hit = (BUS_TIMEOUT != 0) && (wcnt == BUS_TIMEOUT - 1);

    // Every transition into an access state presents that access's strobe,
    // address and data on the same edge, so outputs stay registered and each
    // access costs one clock plus its wait cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= S_FETCH;
            nRead   <= 1'b1;
            nWrite  <= 1'b1;
            address <= '0;
            wdata   <= '0;
            pc      <= '0;
            halted  <= 1'b0;
            fault   <= 1'b0;
            ir      <= '0;
            opa     <= '0;
            opb     <= '0;
            wcnt    <= '0;
        end else begin
            case (st)
                S_HALT: begin
                    nRead  <= 1'b1;
                    nWrite <= 1'b1;
                end
                S_DECODE: begin
                    wcnt <= '0;
                    if (cls > 4'd2) begin
                        st     <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        st      <= S_RD_A;
                        nRead   <= 1'b0;
                        address <= oref(fa);
                    end
                end
                default: begin
                    if (!bus_act) begin
                        // Only reachable in FETCH right after reset: start the
                        // first fetch. ready is ignored while strobes are high.
                        nRead   <= 1'b0;
                        address <= faddr(pc);
                        wcnt    <= '0;
                    end else if (ready) begin
                        wcnt   <= '0;
                        nRead  <= 1'b1;
                        nWrite <= 1'b1;
                        case (st)
                            S_FETCH: begin
                                ir <= rdata[31:0];
                                st <= S_DECODE;
                            end
                            S_RD_A: begin
                                opa <= rdata;
                                if (is_imm) begin
                                    opb     <= DATA_W'(fb);
                                    st      <= S_WR_A;
                                    nWrite  <= 1'b0;
                                    address <= ubase;
                                    wdata   <= rdata;
                                end else begin
                                    st      <= S_RD_B;
                                    nRead   <= 1'b0;
                                    address <= oref(fb);
                                end
                            end
                            S_RD_B: begin
                                opb     <= rdata;
                                st      <= S_WR_A;
                                nWrite  <= 1'b0;
                                address <= ubase;
                                wdata   <= opa;
                            end
                            S_WR_A: begin
                                st      <= S_WR_B;
                                nWrite  <= 1'b0;
                                address <= ubase + ADDR_W'(1);
                                wdata   <= opb;
                            end
                            S_WR_B: begin
                                st      <= S_RD_RES;
                                nRead   <= 1'b0;
                                address <= res_addr;
                            end
                            S_RD_RES: begin
                                if (cls == 4'd2) begin
                                    pc      <= pc_cond;
                                    st      <= S_FETCH;
                                    nRead   <= 1'b0;
                                    address <= faddr(pc_cond);
                                end else begin
                                    // wdata doubles as the result register.
                                    st      <= S_WB;
                                    nWrite  <= 1'b0;
                                    address <= oref(fd);
                                    wdata   <= rdata;
                                end
                            end
                            S_WB: begin
                                pc      <= pc_inc;
                                st      <= S_FETCH;
                                nRead   <= 1'b0;
                                address <= faddr(pc_inc);
                            end
                            default: ;
                        endcase
                    end else if (timeout_hit) begin
                        st     <= S_HALT;
                        halted <= 1'b1;
                        fault  <= 1'b1;
                        nRead  <= 1'b1;
                        nWrite <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 32'd1;
                    end
                end
            endcase
        end
    end

endmodule
